lane_record_packer: RTL and testbench

Per-lane drain stage that sits directly downstream of one lane's width-converting FIFO (fed by the task dispatcher). It pops 32-bit words through the FIFO's one-cycle-latency read port and repacks them into record-framed beats on a ready/valid output with `m_last`. It reports each record's word count and truncates oversize records with an error flag. A small credit-controlled beat buffer absorbs the FIFO read latency, so the block sustains one word per cycle under back-pressure.

---
 rtl/lane_record_packer_pkg.sv | 22 ++
 rtl/lane_record_packer_if.sv | 31 +++
 rtl/lane_record_packer_beat_buffer.sv | 47 ++++
 rtl/lane_record_packer.sv | 121 ++++++++++++
 tb/tb_lane_record_packer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lane_record_packer_pkg.sv
// lane_record_packer shared types.
// Record FSM states and the buffered beat bundle.
package lane_pkg;

  localparam int LANE_DW        = 32;
  localparam int LANE_MAX_WORDS = 16;
  localparam int LANE_WC_W      = $clog2(LANE_MAX_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    DROP
  } rec_state_e;

  typedef struct packed {
    logic [LANE_DW-1:0]   data;
    logic                 last;
    logic [LANE_WC_W-1:0] words;
    logic                 err;
  } beat_t;

endpackage

// File: rtl/lane_record_packer_if.sv
// Record-framed beat stream leaving the lane packer.
// Plain valid/ready handshake with record sideband.
interface lane_record_packer_if #(
  parameter int DW   = 32,
  parameter int WC_W = 5
);
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic            m_last;
  logic [WC_W-1:0] m_words;
  logic            m_err;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    output m_words,
    output m_err,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    input  m_words,
    input  m_err,
    output m_ready
  );
endinterface

// File: rtl/lane_record_packer_beat_buffer.sv
// Small synchronous FIFO of beats between the record FSM
// and the output port; head entry drives the stream directly.
module beat_buffer
  import lane_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int OW    = AW + 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          push,
  input  beat_t         din,
  input  logic          pop,
  output beat_t         dout,
  output logic [OW-1:0] occ,
  output logic          empty
);
  beat_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Entries are cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (occ == '0);

endmodule

// File: rtl/lane_record_packer.sv
// Lane drain stage: pops FIFO words under a credit rule
// and repacks them into framed, length-limited records.
module lane_record_packer
  import lane_pkg::*;
#(
  parameter int DATA_WIDTH = LANE_DW,
  parameter int MAX_WORDS  = LANE_MAX_WORDS,
  parameter int BUF_DEPTH  = 4,
  parameter int WC_W       = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  f_empty,
  output logic                  f_rd_en,
  input  logic                  f_valid,
  input  logic [DATA_WIDTH-1:0] f_dout,
  input  logic                  f_last,
  lane_record_packer_if.master  m,
  output logic [15:0]           rec_cnt,
  output logic                  overrun
);
  localparam int OW = $clog2(BUF_DEPTH) + 1;

  rec_state_e      state_q;
  rec_state_e      state_d;
  logic [WC_W-1:0] wc_q;
  logic [WC_W-1:0] wc_d;
  logic [WC_W-1:0] n;
  logic            inflight;
  logic            accept;
  logic            push;
  logic            pop;
  logic            empty;
  logic [OW-1:0]   occ;
  logic [OW-1:0]   credit;
  beat_t           bin;
  beat_t           head;

  // A read is only issued if its word is sure to find a slot.
  assign credit  = occ + OW'(inflight);
  assign f_rd_en = nrst && !f_empty
                && (credit < OW'(BUF_DEPTH));
  assign accept  = f_valid && inflight;
  assign pop     = m.m_valid && m.m_ready;
  assign n       = wc_q + WC_W'(1);

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    push    = 1'b0;
    bin     = '0;
    unique case (state_q)
      IDLE, BODY: begin
        if (accept) begin
          push     = 1'b1;
          bin.data = f_dout;
          if (f_last) begin
            bin.last  = 1'b1;
            bin.words = n;
            wc_d      = '0;
            state_d   = IDLE;
          end else if (n == WC_W'(MAX_WORDS)) begin
            bin.last  = 1'b1;
            bin.words = WC_W'(MAX_WORDS);
            bin.err   = 1'b1;
            state_d   = DROP;
          end else begin
            wc_d    = n;
            state_d = BODY;
          end
        end
      end
      DROP: begin
        if (accept && f_last) begin
          wc_d    = '0;
          state_d = IDLE;
        end
      end
      default: begin
        wc_d    = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      wc_q     <= '0;
      inflight <= 1'b0;
      rec_cnt  <= '0;
      overrun  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wc_q     <= wc_d;
      inflight <= f_rd_en;
      if (push && bin.last) rec_cnt <= rec_cnt + 16'd1;
      if (push && bin.err) overrun <= 1'b1;
    end
  end

  beat_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .din   (bin),
    .pop   (pop),
    .dout  (head),
    .occ   (occ),
    .empty (empty)
  );

  assign m.m_valid = !empty;
  assign m.m_data  = head.data;
  assign m.m_last  = head.last;
  assign m.m_words = head.words;
  assign m.m_err   = head.err;

endmodule

// File: tb/tb_lane_record_packer.sv
// Directed bench for lane_record_packer: FIFO responder,
// beat scoreboard and per-scenario timing checks.
module tb_lane_record_packer;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [4:0]  w;
    logic        e;
  } exp_t;

  logic        clk;
  logic        nrst;
  logic        f_empty;
  logic        f_rd_en;
  logic        f_valid;
  logic [31:0] f_dout;
  logic        f_last;
  logic [15:0] rec_cnt;
  logic        overrun;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          t;
  bit          toggle = 0;
  bit          phase = 0;
  logic [32:0] src_q [$];
  exp_t        sb [$];
  int          beat_cyc [$];

  lane_record_packer_if #(.DW(32), .WC_W(5)) mi ();

  lane_record_packer dut (
    .clk     (clk),
    .nrst    (nrst),
    .f_empty (f_empty),
    .f_rd_en (f_rd_en),
    .f_valid (f_valid),
    .f_dout  (f_dout),
    .f_last  (f_last),
    .m       (mi),
    .rec_cnt (rec_cnt),
    .overrun (overrun)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Queue a record's words and its expected beats.
  task automatic add_rec(int k, bit term);
    logic [31:0] d;
    bit          l;
    exp_t        e;
    for (int i = 0; i < k; i++) begin
      d = $urandom;
      l = term && (i == k - 1);
      src_q.push_back({l, d});
      if (i < 16) begin
        e.d = d;
        e.l = l || (i == 15);
        e.w = (i == 15) ? 5'd16 : 5'(i + 1);
        e.e = (i == 15) && !l;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_drain(string tag);
    int n;
    n = 0;
    while (n < 300 && (src_q.size() != 0 || sb.size() != 0
           || f_valid || f_rd_en || mi.m_valid)) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Lane FIFO model: one-cycle read latency.
  initial begin
    logic [32:0] w;
    bit          rd;
    f_valid = 0;
    f_dout  = 0;
    f_last  = 0;
    f_empty = 1;
    forever begin
      @(negedge clk);
      rd = f_rd_en;
      @(posedge clk);
      #1;
      if (rd && src_q.size() != 0) begin
        w       = src_q.pop_front();
        f_valid = 1;
        f_dout  = w[31:0];
        f_last  = w[32];
      end else begin
        f_valid = 0;
        f_last  = 0;
      end
      phase   = ~phase;
      f_empty = (src_q.size() == 0) || (toggle && phase);
    end
  end

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (nrst) begin
      check("rd_while_empty", f_rd_en & f_empty, 0);
      if (f_rd_en) rd_cnt++;
      if (dut.push && !(mi.m_valid && mi.m_ready))
        check("push_full", dut.occ == 3'd4, 0);
      if (mi.m_valid && mi.m_ready) begin
        beat_cyc.push_back(cyc);
        check("beat_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("data", mi.m_data, e.d);
          check("last", mi.m_last, e.l);
          if (e.l) begin
            check("words", mi.m_words, e.w);
            check("err", mi.m_err, e.e);
          end
        end
      end
    end
  end

  initial begin
    nrst       = 0;
    mi.m_ready = 1;
    #1;
    check("rst_rd_en", f_rd_en, 0);
    check("rst_valid", mi.m_valid, 0);
    check("rst_data", mi.m_data, 0);
    check("rst_last", mi.m_last, 0);
    check("rst_words", mi.m_words, 0);
    check("rst_err", mi.m_err, 0);
    check("rst_rec_cnt", rec_cnt, 0);
    check("rst_overrun", overrun, 0);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1;
    @(posedge clk);
    #1;

    // Three-word record and its latency.
    beat_cyc.delete();
    add_rec(3, 1);
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      @(negedge clk);
      if (f_rd_en) t = cyc;
    end
    wait_drain("t1_drain");
    check("t1_beats", beat_cyc.size(), 3);
    if (beat_cyc.size() == 3)
      for (int i = 0; i < 3; i++)
        check("t1_latency", beat_cyc[i], t + 2 + i);
    check("t1_rec_cnt", rec_cnt, 1);

    // Back-to-back single-word records.
    beat_cyc.delete();
    for (int i = 0; i < 20; i++) add_rec(1, 1);
    wait_drain("t2_drain");
    check("t2_beats", beat_cyc.size(), 20);
    if (beat_cyc.size() == 20)
      check("t2_span", beat_cyc[19] - beat_cyc[0], 19);
    check("t2_rec_cnt", rec_cnt, 21);

    // Back-pressure: only BUF_DEPTH reads outstanding.
    mi.m_ready = 0;
    rd_cnt = 0;
    add_rec(12, 1);
    repeat (10) @(posedge clk);
    #1;
    check("t3_reads", rd_cnt, 4);
    check("t3_occ", dut.occ, 4);
    beat_cyc.delete();
    mi.m_ready = 1;
    wait_drain("t3_drain");
    check("t3_beats", beat_cyc.size(), 12);
    if (beat_cyc.size() == 12)
      check("t3_span", beat_cyc[11] - beat_cyc[0], 11);
    check("t3_rec_cnt", rec_cnt, 22);

    // Oversize record is truncated, next one is clean.
    beat_cyc.delete();
    check("t4_overrun_pre", overrun, 0);
    add_rec(20, 1);
    add_rec(2, 1);
    wait_drain("t4_drain");
    check("t4_beats", beat_cyc.size(), 18);
    check("t4_overrun", overrun, 1);
    check("t4_rec_cnt", rec_cnt, 24);

    // Reset with two words of a record buffered.
    mi.m_ready = 0;
    add_rec(2, 0);
    for (int i = 0; i < 20 && dut.occ != 3'd2; i++)
      @(negedge clk);
    check("t5_buffered", dut.occ, 2);
    @(posedge clk);
    #1;
    nrst = 0;
    #1;
    check("t5_rd_en", f_rd_en, 0);
    check("t5_valid", mi.m_valid, 0);
    check("t5_data", mi.m_data, 0);
    check("t5_last", mi.m_last, 0);
    check("t5_words", mi.m_words, 0);
    check("t5_err", mi.m_err, 0);
    check("t5_rec_cnt", rec_cnt, 0);
    check("t5_overrun", overrun, 0);
    check("t5_occ", dut.occ, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1;
    mi.m_ready = 1;
    beat_cyc.delete();
    add_rec(3, 1);
    wait_drain("t5_drain");
    check("t5_beats", beat_cyc.size(), 3);
    check("t5_rec_cnt_after", rec_cnt, 1);

    // FIFO empty flag toggling every cycle.
    toggle = 1;
    beat_cyc.delete();
    for (int i = 0; i < 5; i++) add_rec(3, 1);
    wait_drain("t6_drain");
    check("t6_beats", beat_cyc.size(), 15);
    check("t6_rec_cnt", rec_cnt, 6);
    toggle = 0;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
